// File: rtl/nios_mul_pkg.sv
// rtl/nios_mul_pkg.sv - shared types and constants for the Nios multi-cycle multiply sequencer
package nios_mul_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIX} state_t;

  localparam int MUL_LATENCY_MAX = 2;

  // Bit position of partial product k inside the 64-bit accumulator
  localparam int PP_SHIFT [4] = '{0, 16, 16, 32};

  function automatic logic [63:0] place_pp(input logic [31:0] pp, input logic [1:0] k);
    return {32'd0, pp} << PP_SHIFT[k];
  endfunction

endpackage

// File: rtl/mul16_pipe.sv
// rtl/mul16_pipe.sv - pipelined 16x16 unsigned multiplier carrying a {valid,k} tag
module mul16_pipe
  import nios_mul_pkg::*;
#(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [1:0]  in_k,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] prod,
  output logic        out_valid,
  output logic [1:0]  out_k
);

  localparam int LAT = (MUL_LATENCY < 1) ? 1 :
                       (MUL_LATENCY > MUL_LATENCY_MAX) ? MUL_LATENCY_MAX : MUL_LATENCY;

  logic [31:0] prod_q [LAT];
  logic [2:0]  tag_q  [LAT];

  // Product data is left free-running; only the tags are killed on flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) begin
        prod_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      prod_q[0] <= 32'(a) * 32'(b);
      tag_q[0]  <= flush ? 3'b000 : {in_valid, in_k};
      for (int i = 1; i < LAT; i++) begin
        prod_q[i] <= prod_q[i-1];
        tag_q[i]  <= flush ? 3'b000 : tag_q[i-1];
      end
    end
  end

  assign prod               = prod_q[LAT-1];
  assign {out_valid, out_k} = tag_q[LAT-1];

endmodule

// File: rtl/nios_mulh_sequencer.sv
// rtl/nios_mulh_sequencer.sv - 32x32->64 multiply via four 16x16 partial products plus signed fix-up
module nios_mulh_sequencer
  import nios_mul_pkg::*;
#(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        sign1,
  input  logic        sign2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo
);

  state_t      state_q, state_d;
  logic [1:0]  k_q;
  logic [31:0] a_q, b_q;
  logic        s1_q, s2_q;
  logic [63:0] acc_q;
  logic [15:0] mul_a, mul_b;
  logic [31:0] pp;
  logic        pp_valid;
  logic [1:0]  pp_k;
  logic [31:0] hi_fix;
  logic        accept;

  assign accept = (state_q == IDLE) && start && !flush;
  assign busy   = (state_q != IDLE);

  // k bit 0 selects the high half of a, k bit 1 the high half of b
  assign mul_a = k_q[0] ? a_q[31:16] : a_q[15:0];
  assign mul_b = k_q[1] ? b_q[31:16] : b_q[15:0];

  mul16_pipe #(.MUL_LATENCY(MUL_LATENCY)) u_mul (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (state_q == ISSUE),
    .in_k      (k_q),
    .a         (mul_a),
    .b         (mul_b),
    .prod      (pp),
    .out_valid (pp_valid),
    .out_k     (pp_k)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = ISSUE;
        ISSUE:   if (k_q == 2'd3) state_d = DRAIN;
        DRAIN:   if (pp_valid && pp_k == 2'd3) state_d = FIX;
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Unsigned product minus the two's-complement corrections on the high word
  assign hi_fix = acc_q[63:32]
                - ((s1_q && a_q[31]) ? b_q : 32'd0)
                - ((s2_q && b_q[31]) ? a_q : 32'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      acc_q     <= '0;
      done      <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q   <= src1;
        b_q   <= src2;
        s1_q  <= sign1;
        s2_q  <= sign2;
        acc_q <= '0;
        k_q   <= '0;
      end
      if (state_q == ISSUE) k_q <= k_q + 2'd1;
      if (pp_valid && !flush) acc_q <= acc_q + place_pp(pp, pp_k);
      if (state_q == FIX && !flush) begin
        result_hi <= hi_fix;
        result_lo <= acc_q[31:0];
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nios_mulh_sequencer.sv
// tb/tb_nios_mulh_sequencer.sv - self-checking bench, latency 1 and 2 instances against a product model
module tb_nios_mulh_sequencer;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start [N];
  logic        flush [N];
  logic        sign1 [N];
  logic        sign2 [N];
  logic [31:0] src1  [N];
  logic [31:0] src2  [N];
  logic        busy  [N];
  logic        done  [N];
  logic [31:0] rhi   [N];
  logic [31:0] rlo   [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    nios_mulh_sequencer #(.MUL_LATENCY(g + 1)) dut (
      .clk       (clk),
      .reset_n   (rst_n),
      .start     (start[g]),
      .flush     (flush[g]),
      .src1      (src1[g]),
      .src2      (src2[g]),
      .sign1     (sign1[g]),
      .sign2     (sign2[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .result_hi (rhi[g]),
      .result_lo (rlo[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s1, input logic s2);
    logic signed [65:0] ea, eb, p;
    ea = s1 ? {{34{a[31]}}, a} : {34'd0, a};
    eb = s2 ? {{34{b[31]}}, b} : {34'd0, b};
    p  = ea * eb;
    return p[63:0];
  endfunction

  // Reference: op accepted when idle, result appears 5+latency edges later, flush kills
  logic        m_busy [N];
  logic        m_done [N];
  logic [31:0] m_hi   [N];
  logic [31:0] m_lo   [N];
  logic [63:0] m_pend [N];
  int          m_cnt  [N];
  logic        prev_done [N];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_busy[i] = 1'b0; m_done[i] = 1'b0; m_hi[i] = '0; m_lo[i] = '0;
        m_pend[i] = '0;   m_cnt[i] = 0;
      end else begin
        m_done[i] = 1'b0;
        if (flush[i]) begin
          m_busy[i] = 1'b0;
        end else if (!m_busy[i]) begin
          if (start[i]) begin
            m_busy[i] = 1'b1;
            m_cnt[i]  = 0;
            m_pend[i] = exp_prod(src1[i], src2[i], sign1[i], sign2[i]);
          end
        end else begin
          m_cnt[i]++;
          if (m_cnt[i] == 5 + i + 1) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
            m_hi[i]   = m_pend[i][63:32];
            m_lo[i]   = m_pend[i][31:0];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      chk($sformatf("busy%0d", i), 64'(busy[i]), 64'(m_busy[i]));
      chk($sformatf("done%0d", i), 64'(done[i]), 64'(m_done[i]));
      chk($sformatf("hi%0d", i), 64'(rhi[i]), 64'(m_hi[i]));
      chk($sformatf("lo%0d", i), 64'(rlo[i]), 64'(m_lo[i]));
      chk($sformatf("done_pulse%0d", i), 64'(done[i] && prev_done[i]), 64'd0);
      prev_done[i] = done[i];
    end
  end

  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic s1, input logic s2,
                       output logic [31:0] hi, output logic [31:0] lo, output int lat);
    start[idx] = 1'b1; src1[idx] = a; src2[idx] = b; sign1[idx] = s1; sign2[idx] = s2;
    @(posedge clk); #1;
    start[idx] = 1'b0;
    lat = 0;
    while (!done[idx] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done[idx]) chk("op_timeout", 64'd0, 64'd1);
    hi = rhi[idx];
    lo = rlo[idx];
  endtask

  task automatic idle_watch(input int idx, input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done[idx]) seen++;
    end
  endtask

  task automatic rand_drive(input int idx, input int cycles);
    logic [31:0] pick [4];
    repeat (cycles) begin
      pick = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, $urandom};
      start[idx] = ($urandom_range(0, 7) != 0);
      src1[idx]  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
      src2[idx]  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
      sign1[idx] = 1'($urandom_range(0, 1));
      sign2[idx] = 1'($urandom_range(0, 1));
      flush[idx] = ($urandom_range(0, 127) == 0);
      @(posedge clk); #1;
    end
    start[idx] = 1'b0;
    flush[idx] = 1'b0;
  endtask

  initial begin
    logic [31:0] hi, lo;
    int lat, seen;
    for (int i = 0; i < N; i++) begin
      start[i] = 0; flush[i] = 0; sign1[i] = 0; sign2[i] = 0; src1[i] = '0; src2[i] = '0;
      prev_done[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("reset_busy", 64'(busy[0]), 64'd0);
    chk("reset_done", 64'(done[0]), 64'd0);
    chk("reset_hi", 64'(rhi[0]), 64'd0);
    chk("reset_lo", 64'(rlo[0]), 64'd0);

    chk("model_uu", exp_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0), 64'hFFFF_FFFE_0000_0001);
    chk("model_ss", exp_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1), 64'h0000_0000_0000_0001);
    chk("model_su", exp_prod(32'hFFFF_FFFF, 32'h0000_0002, 1, 0), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("model_min", exp_prod(32'h8000_0000, 32'h8000_0000, 1, 1), 64'h4000_0000_0000_0000);

    do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, hi, lo, lat);
    chk("uu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("uu_lo", 64'(lo), 64'h0000_0001);
    chk("uu_latency", 64'(lat), 64'd6);
    do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, hi, lo, lat);
    chk("ss_hi", 64'(hi), 64'h0);
    chk("ss_lo", 64'(lo), 64'h1);
    do_op(0, 32'hFFFF_FFFF, 32'h0000_0002, 1, 0, hi, lo, lat);
    chk("su_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("su_lo", 64'(lo), 64'hFFFF_FFFE);

    do_op(0, 32'h0001_0000, 32'h0001_0000, 0, 0, hi, lo, lat);
    chk("b2b1_hi", 64'(hi), 64'h1);
    chk("b2b1_lo", 64'(lo), 64'h0);
    do_op(0, 32'h8000_0000, 32'h8000_0000, 1, 1, hi, lo, lat);
    chk("b2b2_hi", 64'(hi), 64'h4000_0000);
    chk("b2b2_lo", 64'(lo), 64'h0);
    chk("b2b2_latency", 64'(lat), 64'd6);

    do_op(1, 32'h0000_0003, 32'h0000_0007, 0, 0, hi, lo, lat);
    chk("lat2_lo", 64'(lo), 64'd21);
    chk("lat2_latency", 64'(lat), 64'd7);

    start[0] = 1'b1; src1[0] = 32'd3; src2[0] = 32'd5; sign1[0] = 0; sign2[0] = 0;
    @(posedge clk); #1;
    src1[0] = 32'd7;
    repeat (3) begin @(posedge clk); #1; end
    start[0] = 1'b0;
    lat = 0;
    while (!done[0] && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("busy_ignore_lo", 64'(rlo[0]), 64'd15);
    @(posedge clk); #1;
    chk("no_queue_busy", 64'(busy[0]), 64'd0);

    start[0] = 1'b1; src1[0] = 32'd9; src2[0] = 32'd9;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    chk("flush_busy", 64'(busy[0]), 64'd0);
    idle_watch(0, 10, seen);
    chk("flush_no_done", 64'(seen), 64'd0);
    chk("flush_keep_lo", 64'(rlo[0]), 64'd15);

    start[0] = 1'b1; src1[0] = 32'd11; src2[0] = 32'd13;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_lo", 64'(rlo[0]), 64'd0);
    chk("rst_hi", 64'(rhi[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_watch(0, 10, seen);
    chk("rst_no_done", 64'(seen), 64'd0);

    fork
      rand_drive(0, 36000);
      rand_drive(1, 36000);
    join
    repeat (12) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
